// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the parametrised sequential multiplier.
//   state_t      : FSM state encoding (IDLE, CALC, DONE)
//   cnt_width()  : iteration counter width for a given operand width
//   cond_negate(): two's-complement negate when requested; callers
//                  zero-extend into MAX_W bits and truncate the result,
//                  which is exact because the low bits of a negation do
//                  not depend on the width it is computed at.
package seq_mult_pkg;

  // Widest value cond_negate handles; bounds WIDTH to MAX_W/2.
  localparam int unsigned MAX_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  function automatic logic [MAX_W-1:0] cond_negate(input logic [MAX_W-1:0] x,
                                                   input logic              neg);
    return neg ? (~x + MAX_W'(1)) : x;
  endfunction

endpackage

// File: rtl/seq_mult_sign_adj.sv
// Sign conditioning for seq_multiplier_param (purely combinational).
//   is_signed, a, b : operands presented with start
//   a_mag_c, b_mag_c: operand magnitudes (raw operands when unsigned)
//   neg_c           : result must be negated (signed, operand signs differ)
//   neg, acc        : registered sign flag and unsigned accumulator sum
//   product_c       : acc, negated when neg is set
module seq_mult_sign_adj
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   a_mag_c,
  output logic [WIDTH-1:0]   b_mag_c,
  output logic               neg_c,
  input  logic               neg,
  input  logic [2*WIDTH-1:0] acc,
  output logic [2*WIDTH-1:0] product_c
);

  localparam int unsigned PW = 2 * WIDTH;

  logic a_neg;
  logic b_neg;

  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];

  // The most negative operand maps onto 2^(WIDTH-1), which still fits unsigned.
  assign a_mag_c = WIDTH'(cond_negate(MAX_W'(a), a_neg));
  assign b_mag_c = WIDTH'(cond_negate(MAX_W'(b), b_neg));
  assign neg_c   = a_neg ^ b_neg;

  assign product_c = PW'(cond_negate(MAX_W'(acc), neg));

endmodule

// File: rtl/seq_multiplier_param.sv
// Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned
// per operation. Magnitudes are multiplied unsigned; the sign is applied when
// the result is written to Product.
//   clk, rst  : clock, synchronous active-high reset
//   start     : request, accepted while ready=1 (IDLE or DONE)
//   is_signed : two's-complement operands when 1, captured with start
//   A, B      : multiplicand / multiplier, captured with start
//   Product   : last completed result, held between operations
//   ready     : able to accept start
//   busy      : iterating
//   done      : one-cycle pulse when Product updates
// Optional build macro SEQ_MULT_EARLY_EXIT_EN: stop iterating as soon as the
// remaining multiplier bits are all zero (at least one iteration).
// WIDTH must be in 2..MAX_W/2.
module seq_multiplier_param
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] Product,
  output logic               ready,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam int unsigned PW    = 2 * WIDTH;

  state_t state;
  state_t state_nxt;
  logic   ready_nxt;
  logic   busy_nxt;
  logic   done_nxt;
  logic   capture_c;

  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic             neg;

  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic             neg_c;
  logic [PW-1:0]    acc_sum_c;
  logic [PW-1:0]    product_c;
  logic [WIDTH-1:0] mplier_shr_c;
  logic             last_c;

  seq_mult_sign_adj #(
    .WIDTH (WIDTH)
  ) u_sign_adj (
    .is_signed (is_signed),
    .a         (A),
    .b         (B),
    .a_mag_c   (a_mag_c),
    .b_mag_c   (b_mag_c),
    .neg_c     (neg_c),
    .neg       (neg),
    .acc       (acc_sum_c),
    .product_c (product_c)
  );

  // mcand is pre-shifted each iteration, so it already carries the bit weight.
  assign acc_sum_c    = acc + (mplier[0] ? mcand : '0);
  assign mplier_shr_c = mplier >> 1;

  // Final iteration detect.
`ifdef SEQ_MULT_EARLY_EXIT_EN
  assign last_c = (cnt == CNT_W'(1)) || (mplier_shr_c == '0);
`else
  assign last_c = (cnt == CNT_W'(1));
`endif

  // FSM state and status flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      ready <= ready_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Next state; status flags are decoded from the next state so they register
  // alongside it.
  always_comb begin
    state_nxt = state;
    capture_c = 1'b0;
    ready_nxt = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = CALC;
          capture_c = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      CALC: begin
        if (last_c) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
    ready_nxt = (state_nxt != CALC);
    busy_nxt  = (state_nxt == CALC);
    done_nxt  = (state_nxt == DONE);
  end

  // Datapath: operand capture, shift-add iterations, result write.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      Product <= '0;
    end else if (capture_c) begin
      cnt    <= CNT_W'(WIDTH);
      mcand  <= PW'(a_mag_c);
      mplier <= b_mag_c;
      acc    <= '0;
      neg    <= neg_c;
    end else if (state == CALC) begin
      cnt    <= cnt - CNT_W'(1);
      mcand  <= mcand << 1;
      mplier <= mplier_shr_c;
      acc    <= acc_sum_c;
      if (last_c) Product <= product_c;
    end
  end

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Scoreboard bench for seq_multiplier_param (WIDTH=8): issued operations push
// the hand-computed product and the cycle of its done pulse; a monitor pops
// and compares on every done.
module tb_seq_multiplier_param;

  localparam int W = 8;
`ifdef SEQ_MULT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [2*W-1:0] p;
    int             cyc;
  } exp_t;

  logic           clk;
  logic           rst;
  logic           start;
  logic           is_signed;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] product;
  logic           ready;
  logic           busy;
  logic           done;

  exp_t sb[$];
  int   cyc;
  int   total;
  int   bad;

  seq_multiplier_param #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .A         (a),
    .B         (b),
    .Product   (product),
    .ready     (ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Iterations the design should take for multiplier operand bv.
  function automatic int iters(input logic [W-1:0] bv, input logic s);
    logic [W-1:0] m;
    int n;
    m = (s && bv[W-1]) ? W'(-bv) : bv;
    n = 1;
    for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
    return EARLY ? n : W;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Called just after a negedge; the following posedge accepts the start.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s,
                       input bit push, input logic [2*W-1:0] exp);
    exp_t e;
    a = av;
    b = bv;
    is_signed = s;
    start = 1'b1;
    if (push) begin
      e.p = exp;
      e.cyc = cyc + 1 + iters(bv, s);
      sb.push_back(e);
    end
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk); #1;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL done_timeout pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done actual=1 required=0 at cycle %0d product=%h", cyc, product);
        end else begin
          e = sb.pop_front();
          chk("product", 32'(product), 32'(e.p));
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("ready_at_done", 32'(ready), 32'd1);
          chk("busy_at_done", 32'(busy), 32'd0);
        end
      end
    end
  endtask

  typedef struct {
    logic [W-1:0]   av;
    logic [W-1:0]   bv;
    logic           s;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[5];
  bit   seen;

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_product", 32'(product), 32'h0);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    fork
      monitor();
    join_none
    @(negedge clk); #1;

    // Unsigned full-scale, status flags mid-operation.
    issue(8'hFF, 8'hFF, 1'b0, 1'b1, 16'hFE01);
    @(negedge clk); #1;
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_ready", 32'(ready), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    wait_idle();

    // Signed and unsigned directed vectors.
    vecs[0] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
    vecs[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[2] = '{8'h05, 8'hFD, 1'b1, 16'hFFF1};
    vecs[3] = '{8'h00, 8'h37, 1'b0, 16'h0000};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    foreach (vecs[i]) begin
      issue(vecs[i].av, vecs[i].bv, vecs[i].s, 1'b1, vecs[i].p);
      wait_idle();
    end

    // Start while busy is ignored; previous result held meanwhile.
    issue(8'd3, 8'd5, 1'b0, 1'b1, 16'h000F);
    repeat (2) begin @(negedge clk); #1; end
    chk("ignore_busy", 32'(busy), 32'd1);
    chk("hold_prev", 32'(product), 32'h0001);
    a = 8'd9;
    b = 8'd9;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_idle();
    repeat (12) @(negedge clk);
    #1;

    // Back-to-back start in the DONE cycle.
    issue(8'd7, 8'd3, 1'b0, 1'b1, 16'h0015);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("b2b_first_done_seen", 32'(seen), 32'd1);
    issue(8'd12, 8'd12, 1'b0, 1'b1, 16'h0090);
    @(negedge clk); #1;
    chk("b2b_hold_first", 32'(product), 32'h0015);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_idle();

    // Reset in the middle of an operation.
    issue(8'hAB, 8'hF1, 1'b0, 1'b0, 16'h0000);
    repeat (3) begin @(negedge clk); #1; end
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rst_mid_product", 32'(product), 32'h0);
    chk("rst_mid_ready", 32'(ready), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    chk("rst_after_busy", 32'(busy), 32'd0);
    issue(8'd7, 8'd6, 1'b0, 1'b1, 16'h002A);
    wait_idle();

    // Small multipliers (short under early exit) and zero multiplier.
    issue(8'd5, 8'd3, 1'b0, 1'b1, 16'h000F);
    wait_idle();
    issue(8'h5A, 8'h00, 1'b0, 1'b1, 16'h0000);
    wait_idle();

    repeat (12) @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
